// File: rtl/arm_reg_pkg.sv
// Shared ARM register-file definitions: widths, mode encodings, physical register
// indices, sequencer state/config types and small list helpers.
package arm_reg_pkg;

    localparam int unsigned DATA_W        = 32;
    localparam int unsigned LIST_W        = 16;
    localparam int unsigned RNUM_W        = 5;
    localparam int unsigned LNUM_W        = 4;
    localparam int unsigned MODE_W        = 5;
    localparam int unsigned NUM_PHYS_REGS = 37;

    localparam logic [MODE_W-1:0] MODE_USR = 5'b10000;
    localparam logic [MODE_W-1:0] MODE_FIQ = 5'b10001;
    localparam logic [MODE_W-1:0] MODE_IRQ = 5'b10010;
    localparam logic [MODE_W-1:0] MODE_SVC = 5'b10011;
    localparam logic [MODE_W-1:0] MODE_ABT = 5'b10111;
    localparam logic [MODE_W-1:0] MODE_UND = 5'b11011;
    localparam logic [MODE_W-1:0] MODE_SYS = 5'b11111;

    localparam int unsigned PHYS_FIQ_R8   = 16;
    localparam int unsigned PHYS_FIQ_R13  = 21;
    localparam int unsigned PHYS_FIQ_R14  = 22;
    localparam int unsigned PHYS_SVC_R13  = 23;
    localparam int unsigned PHYS_SVC_R14  = 24;
    localparam int unsigned PHYS_ABT_R13  = 25;
    localparam int unsigned PHYS_ABT_R14  = 26;
    localparam int unsigned PHYS_IRQ_R13  = 27;
    localparam int unsigned PHYS_IRQ_R14  = 28;
    localparam int unsigned PHYS_UND_R13  = 29;
    localparam int unsigned PHYS_UND_R14  = 30;
    localparam int unsigned PHYS_SPSR_FIQ = 31;
    localparam int unsigned PHYS_SPSR_SVC = 32;
    localparam int unsigned PHYS_SPSR_ABT = 33;
    localparam int unsigned PHYS_SPSR_IRQ = 34;
    localparam int unsigned PHYS_SPSR_UND = 35;
    localparam int unsigned PHYS_CPSR     = 36;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_XFER,
        ST_DONE
    } seq_state_e;

    // Transfer request captured when start is accepted
    typedef struct packed {
        logic                is_load;
        logic                up;
        logic                pre;
        logic [MODE_W-1:0]   mode;
        logic                user_bank;
        logic [DATA_W-1:0]   base;
    } xfer_cfg_t;

    function automatic logic [4:0] popcount(input logic [LIST_W-1:0] list);
        popcount = 5'd0;
        for (int i = 0; i < int'(LIST_W); i++) begin
            popcount = popcount + 5'(list[i]);
        end
    endfunction

    // Index of the lowest set bit; 0 when the list is empty
    function automatic logic [LNUM_W-1:0] lowest_set(input logic [LIST_W-1:0] list);
        lowest_set = '0;
        for (int i = int'(LIST_W) - 1; i >= 0; i--) begin
            if (list[i]) lowest_set = LNUM_W'(i);
        end
    endfunction

endpackage

// File: rtl/ldm_stm_sequencer_if.sv
// Register-file and word-memory port driven by the LDM/STM sequencer.
interface ldm_stm_sequencer_if;
    import arm_reg_pkg::*;

    logic [RNUM_W-1:0] rf_read_num;
    logic [DATA_W-1:0] rf_read_data;
    logic [RNUM_W-1:0] rf_write_num;
    logic [DATA_W-1:0] rf_write_data;
    logic              rf_regwrite;
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        output rf_read_num, rf_write_num, rf_write_data, rf_regwrite,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  rf_read_data, mem_rdata, mem_ready
    );

    modport slave (
        input  rf_read_num, rf_write_num, rf_write_data, rf_regwrite,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output rf_read_data, mem_rdata, mem_ready
    );

endinterface

// File: rtl/arm_reg_map.sv
// Logical register + processor mode to physical register number (0-30).
module arm_reg_map
    import arm_reg_pkg::*;
(
    input  logic [MODE_W-1:0] mode,
    input  logic              user_bank,
    input  logic [LNUM_W-1:0] log_num,
    output logic [RNUM_W-1:0] phys_num_c
);

    logic [MODE_W-1:0] eff_mode;

    // S-bit transfers see the user bank; unknown modes fall through as user
    always_comb begin
        eff_mode   = user_bank ? MODE_USR : mode;
        phys_num_c = RNUM_W'(log_num);
        case (eff_mode)
            MODE_FIQ: begin
                if (log_num >= 4'd8 && log_num <= 4'd14)
                    phys_num_c = RNUM_W'(PHYS_FIQ_R8) + RNUM_W'(log_num - 4'd8);
            end
            MODE_SVC: begin
                if (log_num == 4'd13)      phys_num_c = RNUM_W'(PHYS_SVC_R13);
                else if (log_num == 4'd14) phys_num_c = RNUM_W'(PHYS_SVC_R14);
            end
            MODE_ABT: begin
                if (log_num == 4'd13)      phys_num_c = RNUM_W'(PHYS_ABT_R13);
                else if (log_num == 4'd14) phys_num_c = RNUM_W'(PHYS_ABT_R14);
            end
            MODE_IRQ: begin
                if (log_num == 4'd13)      phys_num_c = RNUM_W'(PHYS_IRQ_R13);
                else if (log_num == 4'd14) phys_num_c = RNUM_W'(PHYS_IRQ_R14);
            end
            MODE_UND: begin
                if (log_num == 4'd13)      phys_num_c = RNUM_W'(PHYS_UND_R13);
                else if (log_num == 4'd14) phys_num_c = RNUM_W'(PHYS_UND_R14);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM multi-register transfer engine: walks the register list lowest-first,
// one word per memory handshake, and reports the base writeback value.
module ldm_stm_sequencer
    import arm_reg_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                is_load,
    input  logic [LIST_W-1:0]   reg_list,
    input  logic [DATA_W-1:0]   base_addr,
    input  logic                up,
    input  logic                pre,
    input  logic [MODE_W-1:0]   mode,
    input  logic                user_bank,
    ldm_stm_sequencer_if.master bus,
    output logic                busy,
    output logic                done,
    output logic [DATA_W-1:0]   wb_addr
);

    seq_state_e        state_q, state_d;
    xfer_cfg_t         cfg_q;
    logic [LIST_W-1:0] list_q;
    logic [LIST_W-1:0] list_rest;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] wb_q;
    logic [DATA_W-1:0] span;
    logic [DATA_W-1:0] start_addr;
    logic [DATA_W-1:0] wb_val;
    logic [LNUM_W-1:0] cur_reg;
    logic [RNUM_W-1:0] cur_phys;

    logic              mem_req_c;
    logic              mem_we_c;
    logic [DATA_W-1:0] mem_addr_c;
    logic [DATA_W-1:0] mem_wdata_c;
    logic              rf_regwrite_c;
    logic [RNUM_W-1:0] rf_read_num_c;
    logic [RNUM_W-1:0] rf_write_num_c;
    logic [DATA_W-1:0] rf_write_data_c;

    assign cur_reg   = lowest_set(list_q);
    assign list_rest = list_q & (list_q - LIST_W'(1));
    assign span      = DATA_W'(popcount(list_q)) << 2;
    assign wb_val    = cfg_q.up ? (cfg_q.base + span) : (cfg_q.base - span);

    // Lowest register always lands on the lowest address, so every mode walks upward
    always_comb begin
        case ({cfg_q.up, cfg_q.pre})
            2'b10:   start_addr = cfg_q.base;
            2'b11:   start_addr = cfg_q.base + DATA_W'(4);
            2'b00:   start_addr = cfg_q.base - span + DATA_W'(4);
            default: start_addr = cfg_q.base - span;
        endcase
    end

    arm_reg_map u_map (
        .mode       (cfg_q.mode),
        .user_bank  (cfg_q.user_bank),
        .log_num    (cur_reg),
        .phys_num_c (cur_phys)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cfg_q  <= '0;
            list_q <= '0;
            addr_q <= '0;
            wb_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        cfg_q.is_load   <= is_load;
                        cfg_q.up        <= up;
                        cfg_q.pre       <= pre;
                        cfg_q.mode      <= mode;
                        cfg_q.user_bank <= user_bank;
                        cfg_q.base      <= base_addr;
                        list_q          <= reg_list;
                    end
                end
                ST_SETUP: begin
                    addr_q <= start_addr;
                    wb_q   <= wb_val;
                end
                ST_XFER: begin
                    if (bus.mem_ready) begin
                        list_q <= list_rest;
                        addr_q <= addr_q + DATA_W'(4);
                    end
                end
                default: ;
            endcase
        end
    end

    // Next state and port outputs; everything is gated by state so IDLE drives zeros
    always_comb begin
        state_d         = state_q;
        mem_req_c       = 1'b0;
        mem_we_c        = 1'b0;
        mem_addr_c      = '0;
        mem_wdata_c     = '0;
        rf_regwrite_c   = 1'b0;
        rf_read_num_c   = '0;
        rf_write_num_c  = '0;
        rf_write_data_c = '0;
        busy            = 1'b1;
        done            = 1'b0;
        wb_addr         = '0;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) state_d = ST_SETUP;
            end
            ST_SETUP: begin
                state_d = (list_q == '0) ? ST_DONE : ST_XFER;
            end
            ST_XFER: begin
                mem_req_c  = 1'b1;
                mem_we_c   = ~cfg_q.is_load;
                mem_addr_c = addr_q;
                if (!cfg_q.is_load) begin
                    rf_read_num_c = cur_phys;
                    mem_wdata_c   = bus.rf_read_data;
                end else if (bus.mem_ready) begin
                    rf_regwrite_c   = 1'b1;
                    rf_write_num_c  = cur_phys;
                    rf_write_data_c = bus.mem_rdata;
                end
                if (bus.mem_ready && list_rest == '0) state_d = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                wb_addr = wb_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.mem_req       = mem_req_c;
    assign bus.mem_we        = mem_we_c;
    assign bus.mem_addr      = mem_addr_c;
    assign bus.mem_wdata     = mem_wdata_c;
    assign bus.rf_regwrite   = rf_regwrite_c;
    assign bus.rf_read_num   = rf_read_num_c;
    assign bus.rf_write_num  = rf_write_num_c;
    assign bus.rf_write_data = rf_write_data_c;

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Scoreboard bench for ldm_stm_sequencer: directed LDM/STM vectors push expected
// memory/regfile/done events; a negedge monitor pops and compares them.
module tb_ldm_stm_sequencer;

    localparam int K_MEM  = 0;
    localparam int K_RF   = 1;
    localparam int K_DONE = 2;

    localparam logic [4:0] USR = 5'b10000;
    localparam logic [4:0] FIQ = 5'b10001;

    typedef struct {
        int          kind;
        logic        we;
        logic [31:0] a;
        logic [31:0] b;
        int          n;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        is_load = 1'b0;
    logic [15:0] reg_list = '0;
    logic [31:0] base_addr = '0;
    logic        up = 1'b0;
    logic        pre = 1'b0;
    logic [4:0]  mode = USR;
    logic        user_bank = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] wb_addr;

    ldm_stm_sequencer_if bus ();

    ldm_stm_sequencer dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .is_load   (is_load),
        .reg_list  (reg_list),
        .base_addr (base_addr),
        .up        (up),
        .pre       (pre),
        .mode      (mode),
        .user_bank (user_bank),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .wb_addr   (wb_addr)
    );

    always #5 clock = ~clock;

    exp_t        sb[$];
    int          ncmp = 0;
    int          nerr = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          stall = 0;
    int          wcnt;
    int          hold = 0;
    logic [31:0] prev_addr = '0;
    logic        prev_we = 1'b0;
    logic [31:0] rf_mem [0:36];

    always @(posedge clock) cyc++;

    // Memory / register-file responder
    always @(posedge clock or posedge reset) begin
        if (reset)                              wcnt <= 0;
        else if (bus.mem_req && bus.mem_ready)  wcnt <= 0;
        else if (bus.mem_req)                   wcnt <= wcnt + 1;
    end
    assign bus.mem_ready    = bus.mem_req && (wcnt >= stall);
    assign bus.mem_rdata    = bus.mem_addr ^ 32'hFFFF0000;
    assign bus.rf_read_data = rf_mem[bus.rf_read_num];

    function automatic void push(input int k, input logic we, input logic [31:0] a,
                                 input logic [31:0] b, input int n);
        exp_t e;
        e.kind = k; e.we = we; e.a = a; e.b = b; e.n = n;
        sb.push_back(e);
    endfunction

    function automatic void sb_check(input exp_t got, input string name);
        exp_t e;
        ncmp++;
        if (sb.size() == 0) begin
            nerr++;
            $display("FAIL %s: unexpected event we=%b a=%h b=%h n=%0d, none required",
                     name, got.we, got.a, got.b, got.n);
            return;
        end
        e = sb.pop_front();
        if (!(e.kind == got.kind && e.we == got.we && e.a == got.a && e.n == got.n &&
              (e.b == got.b || (got.kind == K_MEM && !got.we)))) begin
            nerr++;
            $display("FAIL %s: got kind=%0d we=%b a=%h b=%h n=%0d, want kind=%0d we=%b a=%h b=%h n=%0d",
                     name, got.kind, got.we, got.a, got.b, got.n, e.kind, e.we, e.a, e.b, e.n);
        end
    endfunction

    // Monitor: memory accepts, regfile writes and done pulses, sampled mid-cycle
    always @(negedge clock) begin
        exp_t got;
        if (reset) begin
            hold = 0;
        end else begin
            if (bus.mem_req) begin
                if (hold > 0) begin
                    ncmp++;
                    if (bus.mem_addr != prev_addr || bus.mem_we != prev_we) begin
                        nerr++;
                        $display("FAIL addr_hold: got addr=%h we=%b, want addr=%h we=%b",
                                 bus.mem_addr, bus.mem_we, prev_addr, prev_we);
                    end
                end
                hold++;
                prev_addr = bus.mem_addr;
                prev_we   = bus.mem_we;
                if (bus.mem_ready) begin
                    got.kind = K_MEM; got.we = bus.mem_we; got.a = bus.mem_addr;
                    got.b = bus.mem_wdata; got.n = hold;
                    sb_check(got, "mem");
                    hold = 0;
                end
            end
            if (bus.rf_regwrite) begin
                got.kind = K_RF; got.we = 1'b0; got.a = 32'(bus.rf_write_num);
                got.b = bus.rf_write_data; got.n = 0;
                sb_check(got, "regwrite");
            end
            if (done) begin
                got.kind = K_DONE; got.we = 1'b0; got.a = wb_addr; got.b = '0;
                got.n = cyc - start_cyc;
                sb_check(got, "done");
            end
        end
    end

    task automatic check_zero(input string name);
        logic [173:0] o;
        o = {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.rf_regwrite,
             bus.rf_write_num, bus.rf_write_data, bus.rf_read_num, busy, done, wb_addr};
        ncmp++;
        if (o != '0) begin
            nerr++;
            $display("FAIL %s: got outputs=%h, want all zero", name, o);
        end
    endtask

    task automatic go(input logic ld, input logic [15:0] lst, input logic [31:0] base,
                      input logic u, input logic p, input logic [4:0] md, input logic ub);
        @(posedge clock); #1;
        is_load = ld; reg_list = lst; base_addr = base;
        up = u; pre = p; mode = md; user_bank = ub;
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((sb.size() != 0 || busy) && k < 300) begin
            @(posedge clock); #1;
            k++;
        end
        if (k >= 300) begin
            ncmp++; nerr++;
            $display("FAIL timeout: got %0d events outstanding, want 0", sb.size());
            sb.delete();
        end
        repeat (2) @(posedge clock);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 37; i++) rf_mem[i] = 32'hDEAD0000 | 32'(i);
        rf_mem[0] = 32'hA; rf_mem[1] = 32'hB; rf_mem[2] = 32'h22; rf_mem[15] = 32'hC;

        repeat (3) @(posedge clock);
        #1;
        check_zero("reset_state");
        reset = 1'b0;

        // STMIA usr, zero wait
        push(K_MEM, 1'b1, 32'h1000, 32'hA, 1);
        push(K_MEM, 1'b1, 32'h1004, 32'hB, 1);
        push(K_MEM, 1'b1, 32'h1008, 32'hC, 1);
        push(K_DONE, 1'b0, 32'h100C, 0, 5);
        go(1'b0, 16'h8003, 32'h1000, 1'b1, 1'b0, USR, 1'b0);
        wait_idle();

        // LDMDB
        push(K_MEM, 1'b0, 32'h1FF0, 0, 1); push(K_RF, 1'b0, 4, 32'hFFFF1FF0, 0);
        push(K_MEM, 1'b0, 32'h1FF4, 0, 1); push(K_RF, 1'b0, 5, 32'hFFFF1FF4, 0);
        push(K_MEM, 1'b0, 32'h1FF8, 0, 1); push(K_RF, 1'b0, 6, 32'hFFFF1FF8, 0);
        push(K_MEM, 1'b0, 32'h1FFC, 0, 1); push(K_RF, 1'b0, 7, 32'hFFFF1FFC, 0);
        push(K_DONE, 1'b0, 32'h1FF0, 0, 6);
        go(1'b1, 16'h00F0, 32'h2000, 1'b0, 1'b1, USR, 1'b0);
        wait_idle();

        // LDMIA in FIQ mode, then the same with the user bank forced
        for (int ub = 0; ub < 2; ub++) begin
            push(K_MEM, 1'b0, 32'h4000, 0, 1); push(K_RF, 1'b0, (ub != 0) ? 8 : 16,  32'hFFFF4000, 0);
            push(K_MEM, 1'b0, 32'h4004, 0, 1); push(K_RF, 1'b0, (ub != 0) ? 13 : 21, 32'hFFFF4004, 0);
            push(K_MEM, 1'b0, 32'h4008, 0, 1); push(K_RF, 1'b0, (ub != 0) ? 14 : 22, 32'hFFFF4008, 0);
            push(K_DONE, 1'b0, 32'h400C, 0, 5);
            go(1'b1, 16'h6100, 32'h4000, 1'b1, 1'b0, FIQ, 1'(ub));
            wait_idle();
        end

        // STMIB with 3 stall cycles per word; stray start pulses in XFER and DONE
        stall = 3;
        push(K_MEM, 1'b1, 32'h4, 32'hA, 4);
        push(K_MEM, 1'b1, 32'h8, 32'h22, 4);
        push(K_DONE, 1'b0, 32'h8, 0, 10);
        go(1'b0, 16'h0005, 32'h0, 1'b1, 1'b1, USR, 1'b0);
        repeat (3) @(posedge clock);
        #1;
        start = 1'b1; reg_list = 16'hFFFF; is_load = 1'b1;
        @(posedge clock); #1;
        start = 1'b0; reg_list = 16'h0005; is_load = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        wait_idle();
        stall = 0;

        // Empty list
        push(K_DONE, 1'b0, 32'h5550, 0, 2);
        go(1'b0, 16'h0000, 32'h5550, 1'b1, 1'b0, USR, 1'b0);
        wait_idle();

        // Address wrap
        push(K_MEM, 1'b1, 32'hFFFFFFF8, 32'hA, 1);
        push(K_MEM, 1'b1, 32'hFFFFFFFC, 32'hB, 1);
        push(K_MEM, 1'b1, 32'h00000000, 32'h22, 1);
        push(K_DONE, 1'b0, 32'h00000004, 0, 5);
        go(1'b0, 16'h0007, 32'hFFFFFFF8, 1'b1, 1'b0, USR, 1'b0);
        wait_idle();

        // Reset during the second LDM transfer
        stall = 3;
        push(K_MEM, 1'b0, 32'h3000, 0, 4);
        push(K_RF, 1'b0, 0, 32'hFFFF3000, 0);
        go(1'b1, 16'h000F, 32'h3000, 1'b1, 1'b0, USR, 1'b0);
        repeat (6) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check_zero("reset_abort");
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        stall = 0;
        repeat (3) @(posedge clock);
        #1;
        ncmp++;
        if (sb.size() != 0 || busy) begin
            nerr++;
            $display("FAIL reset_drain: got pending=%0d busy=%b, want 0 0", sb.size(), busy);
            sb.delete();
        end

        // Normal transfer after reset
        push(K_MEM, 1'b0, 32'h3000, 0, 1); push(K_RF, 1'b0, 0, 32'hFFFF3000, 0);
        push(K_MEM, 1'b0, 32'h3004, 0, 1); push(K_RF, 1'b0, 1, 32'hFFFF3004, 0);
        push(K_DONE, 1'b0, 32'h3008, 0, 4);
        go(1'b1, 16'h0003, 32'h3000, 1'b1, 1'b0, USR, 1'b0);
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
